// File: rtl/sdram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdram_arb_pkg
// Description : Shared types and default sizing for the two-port SDRAM
//               arbiter (FSM state encoding, address/data widths, timeout).
// Revision    : 1.0 - initial release
// ============================================================================
package sdram_arb_pkg;

    localparam int DEF_ADDR_W  = 23;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 255;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT_RD = 2'd2
    } arb_state_t;

endpackage : sdram_arb_pkg
`default_nettype wire

// File: rtl/sdram_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : sdram_rr_pick
// Description : Two-way round-robin pick. With both requests pending the port
//               not granted last wins; with one pending, that one wins.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_rr_pick (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       gnt_o,
    output logic       any_o
);

    assign any_o = |req_i;
    // On contention alternate; otherwise req_i[1] alone decides the single winner.
    assign gnt_o = (&req_i) ? ~last_i : req_i[1];

endmodule : sdram_rr_pick
`default_nettype wire

// File: rtl/sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sdram_arbiter
// Description : Arbitrates two request ports onto a single SDRAM controller
//               command interface. One transaction in flight at a time; reads
//               wait for controller data or give up after TIMEOUT cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_valid,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic              m0_err,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_valid,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic              m1_err,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] ctrl_addr,
    output logic              ctrl_rw,
    output logic [DATA_W-1:0] ctrl_data_in,
    output logic              ctrl_in_valid,
    input  logic              ctrl_busy,
    input  logic              ctrl_out_valid,
    input  logic [DATA_W-1:0] ctrl_data_out
);

    // Counter only has to reach TIMEOUT-1; the timeout fires on that cycle.
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t        state_q, state_d;
    logic              last_q, last_d;      // granted port; doubles as RR history
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ack0_q, ack0_d, ack1_q, ack1_d;
    logic              err0_q, err0_d, err1_q, err1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    logic              pick_gnt;
    logic              pick_any;
    logic              active;

    sdram_rr_pick u_pick (
        .req_i  ({m1_valid, m0_valid}),
        .last_i (last_q),
        .gnt_o  (pick_gnt),
        .any_o  (pick_any)
    );

    // Command bus shows the latched request only while a transaction is open.
    assign active        = (state_q != ST_IDLE);
    assign ctrl_addr     = active ? addr_q  : '0;
    assign ctrl_rw       = active ? we_q    : 1'b0;
    assign ctrl_data_in  = active ? wdata_q : '0;
    assign ctrl_in_valid = (state_q == ST_ISSUE) && !ctrl_busy;

    assign m0_ack   = ack0_q;
    assign m1_ack   = ack1_q;
    assign m0_err   = err0_q;
    assign m1_err   = err1_q;
    assign m0_rdata = rdata0_q;
    assign m1_rdata = rdata1_q;

    // Next-state, request latching, completion pulses and read-data capture.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        err0_d   = 1'b0;
        err1_d   = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    last_d  = pick_gnt;
                    we_d    = pick_gnt ? m1_we    : m0_we;
                    addr_d  = pick_gnt ? m1_addr  : m0_addr;
                    wdata_d = pick_gnt ? m1_wdata : m0_wdata;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!ctrl_busy) begin
                    if (we_q) begin
                        ack0_d  = ~last_q;
                        ack1_d  = last_q;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_WAIT_RD;
                    end
                end
            end
            ST_WAIT_RD: begin
                if (ctrl_out_valid) begin
                    if (last_q) rdata1_d = ctrl_data_out;
                    else        rdata0_d = ctrl_data_out;
                    ack0_d  = ~last_q;
                    ack1_d  = last_q;
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    ack0_d  = ~last_q;
                    ack1_d  = last_q;
                    err0_d  = ~last_q;
                    err1_d  = last_q;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register; reset abandons any open transaction without an ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            last_q   <= 1'b1;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            err0_q   <= err0_d;
            err1_q   <= err1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

endmodule : sdram_arbiter
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_arbiter
// Description : Directed self-checking bench for sdram_arbiter (TIMEOUT = 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_arbiter;

    localparam int ADDR_W  = 23;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              m0_valid = 1'b0, m0_we = 1'b0;
    logic [ADDR_W-1:0] m0_addr = '0;
    logic [DATA_W-1:0] m0_wdata = '0;
    logic              m0_ack, m0_err;
    logic [DATA_W-1:0] m0_rdata;
    logic              m1_valid = 1'b0, m1_we = 1'b0;
    logic [ADDR_W-1:0] m1_addr = '0;
    logic [DATA_W-1:0] m1_wdata = '0;
    logic              m1_ack, m1_err;
    logic [DATA_W-1:0] m1_rdata;
    logic [ADDR_W-1:0] ctrl_addr;
    logic              ctrl_rw;
    logic [DATA_W-1:0] ctrl_data_in;
    logic              ctrl_in_valid;
    logic              ctrl_busy = 1'b0;
    logic              ctrl_out_valid = 1'b0;
    logic [DATA_W-1:0] ctrl_data_out = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sdram_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .m0_valid       (m0_valid),
        .m0_we          (m0_we),
        .m0_addr        (m0_addr),
        .m0_wdata       (m0_wdata),
        .m0_ack         (m0_ack),
        .m0_err         (m0_err),
        .m0_rdata       (m0_rdata),
        .m1_valid       (m1_valid),
        .m1_we          (m1_we),
        .m1_addr        (m1_addr),
        .m1_wdata       (m1_wdata),
        .m1_ack         (m1_ack),
        .m1_err         (m1_err),
        .m1_rdata       (m1_rdata),
        .ctrl_addr      (ctrl_addr),
        .ctrl_rw        (ctrl_rw),
        .ctrl_data_in   (ctrl_data_in),
        .ctrl_in_valid  (ctrl_in_valid),
        .ctrl_busy      (ctrl_busy),
        .ctrl_out_valid (ctrl_out_valid),
        .ctrl_data_out  (ctrl_data_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ADDR_W-1:0] exp_addr;
        // ---------------- reset state ----------------
        tick();
        tick();
        chk("rst_m0_ack", 32'(m0_ack), 32'd0);
        chk("rst_m1_ack", 32'(m1_ack), 32'd0);
        chk("rst_m0_err", 32'(m0_err), 32'd0);
        chk("rst_m1_err", 32'(m1_err), 32'd0);
        chk("rst_m0_rdata", m0_rdata, 32'd0);
        chk("rst_m1_rdata", m1_rdata, 32'd0);
        chk("rst_in_valid", 32'(ctrl_in_valid), 32'd0);
        chk("rst_ctrl_addr", 32'(ctrl_addr), 32'd0);
        rst_n = 1'b1;

        // ---------------- minimum-latency write on m0 ----------------
        m0_valid = 1'b1; m0_we = 1'b1; m0_addr = 23'h000010; m0_wdata = 32'hDEADBEEF;
        tick();                                     // cycle 1: ISSUE
        m0_valid = 1'b0;                            // dropping valid must not abort
        chk("wr_in_valid_c1", 32'(ctrl_in_valid), 32'd1);
        chk("wr_ctrl_addr", 32'(ctrl_addr), 32'h10);
        chk("wr_ctrl_rw", 32'(ctrl_rw), 32'd1);
        chk("wr_ctrl_data", ctrl_data_in, 32'hDEADBEEF);
        chk("wr_ack_c1", 32'(m0_ack), 32'd0);
        tick();                                     // cycle 2: ack
        chk("wr_m0_ack_c2", 32'(m0_ack), 32'd1);
        chk("wr_m1_ack_c2", 32'(m1_ack), 32'd0);
        chk("wr_m0_err_c2", 32'(m0_err), 32'd0);
        chk("wr_in_valid_c2", 32'(ctrl_in_valid), 32'd0);
        chk("wr_idle_addr", 32'(ctrl_addr), 32'd0);
        tick();
        chk("wr_ack_pulse", 32'(m0_ack), 32'd0);

        // ---------------- round robin, both reads held ----------------
        do_reset();
        m0_valid = 1'b1; m0_we = 1'b0; m0_addr = 23'h000100;
        m1_valid = 1'b1; m1_we = 1'b0; m1_addr = 23'h000200;
        for (int i = 0; i < 4; i++) begin
            exp_addr = (i % 2 == 0) ? 23'h000100 : 23'h000200;
            tick();                                 // ISSUE
            chk($sformatf("rr%0d_addr", i), 32'(ctrl_addr), 32'(exp_addr));
            chk($sformatf("rr%0d_rw", i), 32'(ctrl_rw), 32'd0);
            tick();                                 // WAIT_RD
            ctrl_out_valid = 1'b1;
            ctrl_data_out  = 32'hA0 + 32'(i);
            tick();                                 // ack cycle
            ctrl_out_valid = 1'b0;
            if (i == 3) begin
                m0_valid = 1'b0;
                m1_valid = 1'b0;
            end
            chk($sformatf("rr%0d_m0_ack", i), 32'(m0_ack), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("rr%0d_m1_ack", i), 32'(m1_ack), (i % 2 == 1) ? 32'd1 : 32'd0);
            if (i % 2 == 0) chk($sformatf("rr%0d_m0_rdata", i), m0_rdata, 32'hA0 + 32'(i));
            else            chk($sformatf("rr%0d_m1_rdata", i), m1_rdata, 32'hA0 + 32'(i));
        end

        // ---------------- m1 read, data after 6 wait cycles ----------------
        tick();
        m1_valid = 1'b1; m1_we = 1'b0; m1_addr = 23'h7FFFFF;
        tick();                                     // ISSUE
        m1_valid = 1'b0;
        chk("rd1_addr", 32'(ctrl_addr), 32'h7FFFFF);
        chk("rd1_rw", 32'(ctrl_rw), 32'd0);
        chk("rd1_in_valid", 32'(ctrl_in_valid), 32'd1);
        tick();                                     // first WAIT_RD cycle
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("rd1_wait%0d_ack", i), 32'(m1_ack), 32'd0);
            tick();
        end
        ctrl_out_valid = 1'b1; ctrl_data_out = 32'h12345678;   // 6th wait cycle
        tick();
        ctrl_out_valid = 1'b0;
        chk("rd1_m1_ack", 32'(m1_ack), 32'd1);
        chk("rd1_m1_err", 32'(m1_err), 32'd0);
        chk("rd1_m1_rdata", m1_rdata, 32'h12345678);
        chk("rd1_m0_ack", 32'(m0_ack), 32'd0);
        chk("rd1_m0_rdata", m0_rdata, 32'hA2);
        tick();
        chk("rd1_ack_pulse", 32'(m1_ack), 32'd0);
        chk("rd1_rdata_hold", m1_rdata, 32'h12345678);

        // ---------------- busy stalls ISSUE for 10 cycles ----------------
        m0_valid = 1'b1; m0_we = 1'b1; m0_addr = 23'h000055; m0_wdata = 32'h1111;
        ctrl_busy = 1'b1;
        tick();
        m0_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("busy%0d_in_valid", i), 32'(ctrl_in_valid), 32'd0);
            chk($sformatf("busy%0d_ack", i), 32'(m0_ack), 32'd0);
            tick();
        end
        ctrl_busy = 1'b0;
        #1;
        chk("busy_release_in_valid", 32'(ctrl_in_valid), 32'd1);
        chk("busy_release_addr", 32'(ctrl_addr), 32'h55);
        tick();
        chk("busy_m0_ack", 32'(m0_ack), 32'd1);
        chk("busy_m1_ack", 32'(m1_ack), 32'd0);

        // ---------------- read timeout ----------------
        tick();
        m0_valid = 1'b1; m0_we = 1'b0; m0_addr = 23'h000033;
        tick();                                     // ISSUE
        m0_valid = 1'b0;
        tick();                                     // first WAIT_RD cycle
        for (int i = 0; i < TIMEOUT; i++) begin
            chk($sformatf("to_wait%0d_ack", i), 32'(m0_ack), 32'd0);
            tick();
        end
        chk("to_m0_ack", 32'(m0_ack), 32'd1);
        chk("to_m0_err", 32'(m0_err), 32'd1);
        chk("to_m0_rdata", m0_rdata, 32'hA2);
        chk("to_m1_ack", 32'(m1_ack), 32'd0);
        tick();
        chk("to_ack_pulse", 32'(m0_ack), 32'd0);
        chk("to_err_pulse", 32'(m0_err), 32'd0);

        // ---------------- out_valid while IDLE is ignored ----------------
        ctrl_out_valid = 1'b1; ctrl_data_out = 32'hBAD;
        tick();
        ctrl_out_valid = 1'b0;
        chk("idle_ov_m0_ack", 32'(m0_ack), 32'd0);
        chk("idle_ov_m1_ack", 32'(m1_ack), 32'd0);
        chk("idle_ov_m0_rdata", m0_rdata, 32'hA2);
        chk("idle_ov_m1_rdata", m1_rdata, 32'h12345678);

        // ---------------- reset during WAIT_RD ----------------
        m1_valid = 1'b1; m1_we = 1'b0; m1_addr = 23'h000044;
        tick();                                     // ISSUE
        m1_valid = 1'b0;
        tick();                                     // WAIT_RD
        tick();
        chk("rstrd_pre_addr", 32'(ctrl_addr), 32'h44);
        #2 rst_n = 1'b0;
        #1;
        chk("rstrd_idle_addr", 32'(ctrl_addr), 32'd0);
        chk("rstrd_in_valid", 32'(ctrl_in_valid), 32'd0);
        chk("rstrd_m1_rdata", m1_rdata, 32'd0);
        #1 rst_n = 1'b1;
        ctrl_out_valid = 1'b1; ctrl_data_out = 32'h999;
        tick();
        chk("rstrd_late_m1_ack", 32'(m1_ack), 32'd0);
        chk("rstrd_late_m0_ack", 32'(m0_ack), 32'd0);
        tick();
        ctrl_out_valid = 1'b0;
        chk("rstrd_late2_m1_ack", 32'(m1_ack), 32'd0);
        chk("rstrd_late_rdata", m1_rdata, 32'd0);
        chk("rstrd_late_ctrl_addr", 32'(ctrl_addr), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_sdram_arbiter
`default_nettype wire
